// File: rtl/io_seg_pkg.sv
// Shared constants for the LED / seven-segment output peripheral.
// Register addresses, CTRL field positions and the all-off segment code.
package io_seg_pkg;

  localparam logic [1:0] ADDR_LED_LO   = 2'b00;
  localparam logic [1:0] ADDR_LED_HI   = 2'b01;
  localparam logic [1:0] ADDR_DISP_VAL = 2'b10;
  localparam logic [1:0] ADDR_CTRL     = 2'b11;

  localparam int EN_BIT = 0;
  localparam int DP_LSB = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/hex_to_seg7.sv
// Hex nibble to seven-segment pattern, active-high segments {g,f,e,d,c,b,a}.
// Ports: nib (4-bit digit value) -> seg (7-bit segment pattern).
module hex_to_seg7 (
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    unique case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
    endcase
  end

endmodule

// File: rtl/io_led_seg_out.sv
// MMIO output block: LED bank, 32-bit display value and CTRL register,
// scanned as 8 hex digits on a common-anode seven-segment display.
// Ports: sys_clk, sys_rst_n (sync, active-low); io_write/io_addr/io_wdata
// store path; wr_ack write pulse; led[16:0]; seg_an/seg_cat active-low.
// Build option: define SEG_LZB_EN to blank leading-zero digits above 0.
module io_led_seg_out
  import io_seg_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter int NUM_DIGITS = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        io_write,
  input  logic [1:0]  io_addr,
  input  logic [31:0] io_wdata,
  output logic        wr_ack,
  output logic [16:0] led,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PS_MAX = PW'(SCAN_DIV - 1);

  logic [31:0]   disp_val;
  logic          enable;
  logic [7:0]    dp_mask;
  logic [PW-1:0] presc;
  logic [IW-1:0] idx;

  logic [3:0] nib;
  logic [6:0] seg;
  logic       blank;
  logic [7:0] an_nxt;
  logic [7:0] cat_nxt;

  assign nib = disp_val[{idx, 2'b00} +: 4];

  hex_to_seg7 u_hex (
    .nib (nib),
    .seg (seg)
  );

`ifdef SEG_LZB_EN
  // Digit is a leading zero when it and every higher nibble are zero.
  assign blank = (idx != '0) &&
                 ((disp_val >> {idx, 2'b00}) == 32'd0);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an_nxt  = SEG_BLANK;
    cat_nxt = SEG_BLANK;
    if (enable && !blank) begin
      an_nxt  = ~(8'd1 << idx);
      cat_nxt = ~{dp_mask[idx], seg};
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      led      <= '0;
      disp_val <= '0;
      enable   <= 1'b0;
      dp_mask  <= '0;
      presc    <= '0;
      idx      <= '0;
      seg_an   <= SEG_BLANK;
      seg_cat  <= SEG_BLANK;
      wr_ack   <= 1'b0;
    end else begin
      wr_ack <= io_write;
      if (io_write) begin
        unique case (1'b1)
          (io_addr == ADDR_LED_LO):
            led[15:0] <= io_wdata[15:0];
          (io_addr == ADDR_LED_HI):
            led[16] <= io_wdata[0];
          (io_addr == ADDR_DISP_VAL):
            disp_val <= io_wdata;
          (io_addr == ADDR_CTRL): begin
            enable  <= io_wdata[EN_BIT];
            dp_mask <= io_wdata[DP_LSB +: 8];
          end
        endcase
      end
      // Scan keeps running while disabled so re-enable is glitch-free.
      if (presc == PS_MAX) begin
        presc <= '0;
        idx   <= idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
      seg_an  <= an_nxt;
      seg_cat <= cat_nxt;
    end
  end

endmodule

// File: tb/tb_io_led_seg_out.sv
// Scoreboard bench for io_led_seg_out with SCAN_DIV=4.
// Stimulus queues timed expectations; a negedge monitor pops and compares.
module tb_io_led_seg_out;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        io_write;
  logic [1:0]  io_addr;
  logic [31:0] io_wdata;
  logic        wr_ack;
  logic [16:0] led;
  logic [7:0]  seg_an;
  logic [7:0]  seg_cat;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;
  int base = 0;
  logic [16:0] led_e = '0;

  exp_t        mon_e;
  logic [31:0] mon_act;

  io_led_seg_out #(.SCAN_DIV(SD)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .io_write  (io_write),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .wr_ack    (wr_ack),
    .led       (led),
    .seg_an    (seg_an),
    .seg_cat   (seg_cat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] cat_of(input logic [3:0] h);
    case (h)
      4'h0: return 8'hC0;
      4'h1: return 8'hF9;
      4'h2: return 8'hA4;
      4'h3: return 8'hB0;
      4'h4: return 8'h99;
      4'h5: return 8'h92;
      4'h6: return 8'h82;
      4'h7: return 8'hF8;
      4'h8: return 8'h80;
      4'h9: return 8'h90;
      4'hA: return 8'h88;
      4'hB: return 8'h83;
      4'hC: return 8'hC6;
      4'hD: return 8'hA1;
      4'hE: return 8'h86;
      default: return 8'h8E;
    endcase
  endfunction

  // Digit lit at cycle c: scan started at 'base', SD cycles per digit.
  function automatic logic [15:0] disp(input int c, input logic [31:0] v,
                                       input logic [7:0] dpm, input logic en);
    int d;
    logic [7:0] cat;
    d = ((c - base) / SD) % 8;
    if (!en) return 16'hFFFF;
`ifdef SEG_LZB_EN
    if (d > 0 && (v >> (4 * d)) == 32'd0) return 16'hFFFF;
`endif
    cat = cat_of(v[4*d +: 4]);
    if (dpm[d]) cat[7] = 1'b0;
    return {~(8'd1 << d), cat};
  endfunction

  task automatic push(input int c, input int s, input logic [31:0] v,
                      input string t);
    exp_t e;
    e.cyc = c;
    e.sel = s;
    e.val = v;
    e.tag = t;
    q.push_back(e);
  endtask

  task automatic span(input int c0, input int len, input logic [31:0] v,
                      input logic [7:0] dpm, input logic en);
    logic [15:0] p;
    for (int c = c0; c < c0 + len; c++) begin
      p = disp(c, v, dpm, en);
      push(c, 2, {24'd0, p[15:8]}, "seg_an");
      push(c, 3, {24'd0, p[7:0]}, "seg_cat");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    io_write = 1'b1;
    io_addr  = a;
    io_wdata = d;
    push(cyc + 1, 1, 32'd1, "wr_ack");
    push(cyc + 1, 0, {15'd0, led_e}, "led");
    @(posedge clk);
    #1;
    io_write = 1'b0;
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      case (mon_e.sel)
        0: mon_act = {15'd0, led};
        1: mon_act = {31'd0, wr_ack};
        2: mon_act = {24'd0, seg_an};
        default: mon_act = {24'd0, seg_cat};
      endcase
      n_run++;
      if (mon_e.cyc < cyc) begin
        n_fail++;
        $display("FAIL %s cyc %0d: check missed at cyc %0d",
                 mon_e.tag, mon_e.cyc, cyc);
      end else if (mon_act !== mon_e.val) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got %h want %h",
                 mon_e.tag, mon_e.cyc, mon_act, mon_e.val);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    io_write = 1'b1;
    io_addr  = 2'b10;
    io_wdata = 32'hFFFF_FFFF;
    push(2, 0, 32'd0, "rst_led");
    push(2, 1, 32'd0, "rst_ack");
    push(2, 2, 32'hFF, "rst_an");
    push(2, 3, 32'hFF, "rst_cat");
    idle(3);
    rst_n    = 1'b1;
    io_write = 1'b0;
    base     = cyc + 1;

    // LED bank, back-to-back writes
    led_e = 17'h0ABCD;
    wr(2'b00, 32'h0000_ABCD);
    led_e = 17'h1ABCD;
    wr(2'b01, 32'h0000_0001);
    push(cyc + 1, 1, 32'd0, "ack_drop");
    push(cyc + 1, 0, {15'd0, led_e}, "led_hold");
    idle(2);

    // enable with reset-cleared value: all zeros
    wr(2'b11, 32'h0000_0001);
    span(cyc + 1, 8, 32'h0, 8'h00, 1'b1);
    idle(9);

    // full scan
    wr(2'b10, 32'h7654_3210);
    span(cyc + 1, 34, 32'h7654_3210, 8'h00, 1'b1);
    idle(35);

    // decimal point on digit 0
    wr(2'b11, 32'h0000_0101);
    span(cyc + 1, 32, 32'h7654_3210, 8'h01, 1'b1);
    idle(33);

    // disable
    wr(2'b11, 32'h0000_0000);
    span(cyc + 1, 6, 32'h7654_3210, 8'h01, 1'b0);
    idle(7);

    // remaining hex glyphs
    wr(2'b11, 32'h0000_0001);
    wr(2'b10, 32'hFEDC_BA98);
    span(cyc + 1, 32, 32'hFEDC_BA98, 8'h00, 1'b1);
    idle(33);

    // write lands on the digit 2->3 wrap edge
    while (((cyc - base + 2) % 32) != 12) idle(1);
    span(cyc + 1, 1, 32'hFEDC_BA98, 8'h00, 1'b1);
    wr(2'b10, 32'h0000_F000);
    span(cyc + 1, 8, 32'h0000_F000, 8'h00, 1'b1);
    idle(9);

    // small values (leading zeros)
    wr(2'b10, 32'h0000_00A5);
    span(cyc + 1, 32, 32'h0000_00A5, 8'h00, 1'b1);
    idle(33);
    wr(2'b10, 32'h0000_0000);
    span(cyc + 1, 32, 32'h0, 8'h00, 1'b1);
    idle(33);

    // reset mid-scan while writing
    rst_n    = 1'b0;
    io_write = 1'b1;
    io_addr  = 2'b00;
    io_wdata = 32'h0000_FFFF;
    idle(1);
    push(cyc, 0, 32'd0, "mid_rst_led");
    push(cyc, 1, 32'd0, "mid_rst_ack");
    push(cyc, 2, 32'hFF, "mid_rst_an");
    push(cyc, 3, 32'hFF, "mid_rst_cat");
    idle(1);
    rst_n    = 1'b1;
    io_write = 1'b0;

    repeat (40) begin
      if (q.size() == 0) break;
      idle(1);
    end
    if (q.size() != 0) begin
      $display("FAIL drain: %0d checks pending, want 0", q.size());
      n_run  += q.size();
      n_fail += q.size();
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
